// File: rtl/div_unit_32.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Optional feature: define DIV_EARLY_OUT_EN to finish in one cycle when |divisor| > |dividend|.
module div_unit_32 #(
   parameter int unsigned XLEN = 32
) (
   input  logic            CLK,
   input  logic            RESET_N,
   input  logic            START,
   input  logic [1:0]      FUNC3,
   input  logic [XLEN-1:0] DATA1,
   input  logic [XLEN-1:0] DATA2,
   input  logic            FLUSH,
   output logic            BUSY,
   output logic            VALID,
   output logic [XLEN-1:0] RESULT
);

   localparam int unsigned CntW = $clog2(XLEN);
   localparam logic [CntW-1:0] CntLast = CntW'(XLEN - 1);

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone
   } state_e;

   state_e            state_q, state_d;
   logic [1:0]        func_q, func_d;
   logic              sign1_q, sign1_d;
   logic              sign2_q, sign2_d;
   logic              special_q, special_d;
   logic [XLEN-1:0]   quo_q, quo_d;
   logic [XLEN-1:0]   rem_q, rem_d;
   logic [XLEN-1:0]   dvs_q, dvs_d;
   logic [XLEN-1:0]   result_q, result_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic              valid_q, valid_d;
   logic              busy_q, busy_d;

   logic              is_signed;
   logic [XLEN-1:0]   mag1, mag2;
   logic              div_zero, ovf, early_out;
   logic [XLEN:0]     shifted;
   logic [XLEN+1:0]   diff;
   logic [XLEN-1:0]   q_fix, r_fix;

   always_comb begin
      is_signed = ~FUNC3[0];
      mag1      = (is_signed && DATA1[XLEN-1]) ? (~DATA1 + 1'b1) : DATA1;
      mag2      = (is_signed && DATA2[XLEN-1]) ? (~DATA2 + 1'b1) : DATA2;
      div_zero  = (DATA2 == '0);
      ovf       = is_signed && (DATA1 == {1'b1, {(XLEN-1){1'b0}}}) && (DATA2 == '1);
   end

`ifdef DIV_EARLY_OUT_EN
   assign early_out = (mag2 > mag1);
`else
   assign early_out = 1'b0;
`endif

   // Trial subtraction on the shifted upper part; diff MSB set means the divisor did not fit.
   always_comb begin
      shifted = {rem_q, quo_q[XLEN-1]};
      diff    = {1'b0, shifted} - {2'b00, dvs_q};
   end

   // Special cases already hold final values, so they bypass sign correction.
   always_comb begin
      q_fix = quo_q;
      r_fix = rem_q;
      if (!special_q && (func_q == 2'b00) && (sign1_q ^ sign2_q)) begin
         q_fix = ~quo_q + 1'b1;
      end
      if (!special_q && (func_q == 2'b10) && sign1_q) begin
         r_fix = ~rem_q + 1'b1;
      end
   end

   always_comb begin
      state_d   = state_q;
      func_d    = func_q;
      sign1_d   = sign1_q;
      sign2_d   = sign2_q;
      special_d = special_q;
      quo_d     = quo_q;
      rem_d     = rem_q;
      dvs_d     = dvs_q;
      result_d  = result_q;
      cnt_d     = cnt_q;
      valid_d   = 1'b0;

      case (state_q)
         StIdle: begin
            if (START) begin
               func_d    = FUNC3;
               sign1_d   = is_signed & DATA1[XLEN-1];
               sign2_d   = is_signed & DATA2[XLEN-1];
               dvs_d     = mag2;
               cnt_d     = '0;
               special_d = 1'b0;
               if (div_zero) begin
                  quo_d     = '1;
                  rem_d     = DATA1;
                  special_d = 1'b1;
                  state_d   = StDone;
               end else if (ovf) begin
                  quo_d     = {1'b1, {(XLEN-1){1'b0}}};
                  rem_d     = '0;
                  special_d = 1'b1;
                  state_d   = StDone;
               end else if (early_out) begin
                  quo_d   = '0;
                  rem_d   = mag1;
                  state_d = StDone;
               end else begin
                  quo_d   = mag1;
                  rem_d   = '0;
                  state_d = StRun;
               end
            end
         end
         StRun: begin
            quo_d = {quo_q[XLEN-2:0], ~diff[XLEN+1]};
            rem_d = diff[XLEN+1] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CntLast) begin
               state_d = StDone;
            end
         end
         StDone: begin
            result_d = func_q[1] ? r_fix : q_fix;
            valid_d  = 1'b1;
            state_d  = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // Abort discards the in-flight operation without touching RESULT.
      if (FLUSH) begin
         state_d  = StIdle;
         valid_d  = 1'b0;
         result_d = result_q;
      end

      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q   <= StIdle;
         func_q    <= '0;
         sign1_q   <= 1'b0;
         sign2_q   <= 1'b0;
         special_q <= 1'b0;
         quo_q     <= '0;
         rem_q     <= '0;
         dvs_q     <= '0;
         result_q  <= '0;
         cnt_q     <= '0;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         func_q    <= func_d;
         sign1_q   <= sign1_d;
         sign2_q   <= sign2_d;
         special_q <= special_d;
         quo_q     <= quo_d;
         rem_q     <= rem_d;
         dvs_q     <= dvs_d;
         result_q  <= result_d;
         cnt_q     <= cnt_d;
         valid_q   <= valid_d;
         busy_q    <= busy_d;
      end
   end

   assign BUSY   = busy_q;
   assign VALID  = valid_q;
   assign RESULT = result_q;

endmodule

// File: tb/tb_div_unit_32.sv
// Directed self-checking bench for div_unit_32: results, latency, flush, ignored start, async reset.
// Honours DIV_EARLY_OUT_EN for the early-out latency expectation.
module tb_div_unit_32;

   logic        CLK;
   logic        RESET_N;
   logic        START;
   logic [1:0]  FUNC3;
   logic [31:0] DATA1;
   logic [31:0] DATA2;
   logic        FLUSH;
   logic        BUSY;
   logic        VALID;
   logic [31:0] RESULT;

   int total;
   int passed;

   div_unit_32 #(.XLEN(32)) dut (
      .CLK     (CLK),
      .RESET_N (RESET_N),
      .START   (START),
      .FUNC3   (FUNC3),
      .DATA1   (DATA1),
      .DATA2   (DATA2),
      .FLUSH   (FLUSH),
      .BUSY    (BUSY),
      .VALID   (VALID),
      .RESULT  (RESULT)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Counts cycles until VALID, bounded so a stuck DUT still reaches the summary.
   task automatic wait_valid(inout int n);
      while (VALID !== 1'b1 && n < 40) begin
         @(posedge CLK);
         #1;
         n++;
      end
   endtask

   // Starts an op from mid-cycle; returns mid-cycle in the VALID cycle.
   task automatic do_op(input string tag, input logic [1:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
      int n;
      FUNC3 = f;
      DATA1 = a;
      DATA2 = b;
      START = 1'b1;
      @(posedge CLK);
      #1;
      START = 1'b0;
      n = 0;
      wait_valid(n);
      check({tag, "_lat"}, 32'(n), 32'(exp_lat));
      check({tag, "_res"}, RESULT, exp_res);
      check({tag, "_busy_in_valid"}, {31'd0, BUSY}, 32'd0);
   endtask

   initial begin
      int n;
      int seen;
      int early_lat;
      total   = 0;
      passed  = 0;
      RESET_N = 1'b0;
      START   = 1'b0;
      FLUSH   = 1'b0;
      FUNC3   = 2'b00;
      DATA1   = '0;
      DATA2   = '0;
`ifdef DIV_EARLY_OUT_EN
      early_lat = 1;
`else
      early_lat = 33;
`endif

      #12;
      check("rst_busy", {31'd0, BUSY}, 32'd0);
      check("rst_valid", {31'd0, VALID}, 32'd0);
      check("rst_result", RESULT, 32'd0);
      RESET_N = 1'b1;
      @(posedge CLK);
      #1;

      do_op("divu_100_7", 2'b01, 32'd100, 32'd7, 32'h0000000E, 33);
      @(posedge CLK);
      #1;
      check("valid_one_cycle", {31'd0, VALID}, 32'd0);

      do_op("remu_100_7", 2'b11, 32'd100, 32'd7, 32'h00000002, 33);
      // Chained immediately: START lands in the VALID cycle of the previous op.
      check("b2b_valid_high", {31'd0, VALID}, 32'd1);
      do_op("div_m7_2", 2'b00, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 33);
      do_op("rem_m7_2", 2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 33);
      do_op("div_7_m2", 2'b00, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 33);
      do_op("rem_7_m2", 2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 33);

      do_op("divu_5_0", 2'b01, 32'd5, 32'd0, 32'hFFFFFFFF, 1);
      do_op("rem_m5_0", 2'b10, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 1);
      do_op("div_ovf", 2'b00, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
      do_op("rem_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);

      do_op("divu_3_10", 2'b01, 32'd3, 32'd10, 32'h00000000, early_lat);

      // Second START while busy must be ignored.
      FUNC3 = 2'b01;
      DATA1 = 32'd1000;
      DATA2 = 32'd3;
      START = 1'b1;
      @(posedge CLK);
      #1;
      START = 1'b0;
      n = 0;
      repeat (2) begin
         @(posedge CLK);
         #1;
         n++;
      end
      FUNC3 = 2'b01;
      DATA1 = 32'd5;
      DATA2 = 32'd0;
      START = 1'b1;
      @(posedge CLK);
      #1;
      n++;
      START = 1'b0;
      wait_valid(n);
      check("ignore_start_lat", 32'(n), 32'd33);
      check("ignore_start_res", RESULT, 32'h0000014D);

      // Flush mid-run.
      @(posedge CLK);
      #1;
      FUNC3 = 2'b01;
      DATA1 = 32'd1000;
      DATA2 = 32'd3;
      START = 1'b1;
      @(posedge CLK);
      #1;
      START = 1'b0;
      repeat (9) begin
         @(posedge CLK);
         #1;
      end
      check("flush_busy_before", {31'd0, BUSY}, 32'd1);
      FLUSH = 1'b1;
      @(posedge CLK);
      #1;
      FLUSH = 1'b0;
      check("flush_busy_after", {31'd0, BUSY}, 32'd0);
      check("flush_valid_after", {31'd0, VALID}, 32'd0);
      seen = 0;
      repeat (40) begin
         @(posedge CLK);
         #1;
         if (VALID === 1'b1) seen++;
      end
      check("flush_no_valid", 32'(seen), 32'd0);
      check("flush_result_kept", RESULT, 32'h0000014D);

      // FLUSH beats a simultaneous START.
      FUNC3 = 2'b01;
      DATA1 = 32'd100;
      DATA2 = 32'd7;
      START = 1'b1;
      FLUSH = 1'b1;
      @(posedge CLK);
      #1;
      START = 1'b0;
      FLUSH = 1'b0;
      check("flush_wins_busy", {31'd0, BUSY}, 32'd0);

      // Asynchronous reset mid-run.
      START = 1'b1;
      @(posedge CLK);
      #1;
      START = 1'b0;
      repeat (5) begin
         @(posedge CLK);
         #1;
      end
      check("pre_rst_busy", {31'd0, BUSY}, 32'd1);
      check("pre_rst_result", RESULT, 32'h0000014D);
      #2;
      RESET_N = 1'b0;
      #1;
      check("async_rst_busy", {31'd0, BUSY}, 32'd0);
      check("async_rst_valid", {31'd0, VALID}, 32'd0);
      check("async_rst_result", RESULT, 32'd0);
      #2;
      RESET_N = 1'b1;
      @(posedge CLK);
      #1;
      check("post_rst_busy", {31'd0, BUSY}, 32'd0);

      do_op("post_rst_divu", 2'b01, 32'd100, 32'd7, 32'h0000000E, 33);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
